accum_bank: RTL and testbench
=============================

ACCUM_BANK -- requirements
Module: accum_bank

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16: signed partial-sum input width.
REQ-002 The module SHALL have parameter ACC_WIDTH, default 32: signed accumulator width, ACC_WIDTH >= DATA_WIDTH.
REQ-003 The module SHALL have parameter SYS_ARR_COLS, default 16: number of independent columns.
REQ-004 The module SHALL have parameters MAX_OUT_ROWS and MAX_OUT_COLS, defaults 128 and 128; DEPTH = MAX_OUT_ROWS*(MAX_OUT_COLS/SYS_ARR_COLS), ADDR_W = $clog2(DEPTH).
REQ-005 The module SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  SYS_ARR_COLS  per-column write request.
- in_mode  in  1  0 = accumulate, 1 = overwrite; shared by all columns.
- in_addr  in  ADDR_W*SYS_ARR_COLS  per-column row address.
- in_data  in  DATA_WIDTH*SYS_ARR_COLS  per-column signed partial sum.
- rd_en  in  SYS_ARR_COLS  per-column read request.
- rd_addr  in  ADDR_W*SYS_ARR_COLS  per-column read address.
- rd_valid  out  SYS_ARR_COLS  read data qualifier.
- rd_data  out  ACC_WIDTH*SYS_ARR_COLS  per-column accumulator value.
- clear_start  in  1  request a full-table clear.
- busy  out  1  clear sweep in progress.
- sat_flag  out  SYS_ARR_COLS  saturation event pulse.

Function
REQ-006 Each column SHALL perform a 2-stage read-modify-write: stage 1 registers the request and reads the row; stage 2 writes old+sext(in_data) (accumulate) or sext(in_data) (overwrite).
REQ-007 The write SHALL become visible to a read issued 2 cycles after the request; one request per column per cycle SHALL be sustained.
REQ-008 When stage 2 writes the address stage 1 is reading, stage 1 SHALL use the forwarded stage-2 result, so back-to-back same-address accumulates are exact.
REQ-009 Reads SHALL have 1-cycle latency: rd_valid[c] and rd_data[c] are valid the cycle after rd_en[c]; a read colliding with a same-cycle write returns the pre-write value.
REQ-010 Without saturation, arithmetic SHALL wrap modulo 2^ACC_WIDTH (two's complement).
REQ-011 The clear FSM SHALL have states IDLE and CLEAR; IDLE->CLEAR on clear_start; CLEAR writes zero to row cnt in all columns, cnt increments each cycle; CLEAR->IDLE after row DEPTH-1.
REQ-012 busy SHALL be 1 in CLEAR and 0 in IDLE; clear_start while busy SHALL be ignored.
REQ-013 While busy, in_valid and rd_en SHALL be ignored and rd_valid SHALL be 0; a request already in stage 2 completes, and if its row equals cnt the clear write wins.

Reset
REQ-014 Reset SHALL clear pipeline registers, rd_valid, rd_data, and sat_flag to 0, set cnt to 0, and enter CLEAR (busy = 1), so the table is zeroed after every reset; reset mid-sweep restarts at row 0.
REQ-015 RAM arrays SHALL NOT be reset directly.

Configuration
REQ-016 With ACCUM_BANK_SAT_EN defined, stage 2 SHALL saturate to the signed ACC_WIDTH max/min and pulse sat_flag[c] for one cycle, the cycle after the saturated write.
REQ-017 Without ACCUM_BANK_SAT_EN, arithmetic SHALL wrap per REQ-010 and sat_flag SHALL be tied to 0.

Structure
REQ-018 Package accum_pkg SHALL hold the default parameter values, the in_mode encodings, and the FSM state typedef.
REQ-019 Sub-module accum_bank_col SHALL contain one column's RAM, RMW pipeline, forwarding, and read port; accum_bank SHALL hold the clear FSM and instantiate SYS_ARR_COLS columns in a generate loop.

Verification
REQ-020 Scenario: release reset -> busy stays 1 for 1024 cycles, then 0; read of every row returns 0.
REQ-021 Scenario: col 3, addr 5, accumulate 10, -3, 7 on consecutive cycles -> read at addr 5 two cycles after the last write returns 14 (forwarding).
REQ-022 Scenario: overwrite 100 to addr 7, then accumulate 1 -> read returns 101; a read on the same cycle as the overwrite write returns the old value 0.
REQ-023 Scenario: with ACCUM_BANK_SAT_EN, overwrite 0x7FFFFFF0, then accumulate 0x7FFF -> read returns 0x7FFFFFFF and sat_flag pulses once; without the macro, read returns 0x80007FEF and sat_flag = 0.
REQ-024 Scenario: clear_start mid-traffic -> in_valid is ignored for DEPTH cycles; all rows read 0 afterwards; reset at cycle 500 of the sweep -> the sweep restarts and busy lasts a full 1024 cycles.

Source files
------------

// File: rtl/accum_pkg.sv
// Shared definitions for the accumulator bank.
// Holds the default parameter values, the in_mode encodings and the clear-FSM
// state type. Imported by accum_bank and accum_bank_col.
package accum_pkg;

  localparam int unsigned DataWidthDef  = 16;
  localparam int unsigned AccWidthDef   = 32;
  localparam int unsigned SysArrColsDef = 16;
  localparam int unsigned MaxOutRowsDef = 128;
  localparam int unsigned MaxOutColsDef = 128;

  // Shared write mode applied to every column in a cycle.
  typedef enum logic {
    ModeAccum     = 1'b0,
    ModeOverwrite = 1'b1
  } accum_mode_e;

  // Table clear sequencer.
  typedef enum logic {
    StIdle,
    StClear
  } clr_state_e;

endpackage

// File: rtl/accum_bank_col.sv
// One accumulator column: private RAM, 2-stage read-modify-write pipeline with
// stage-2 -> stage-1 forwarding, a 1-cycle read port and a clear write port.
// Optional saturation is enabled by defining ACCUM_BANK_SAT_EN; otherwise the
// adder wraps and sat_flag_o is tied low.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   busy_i              clear sweep active: new writes/reads are dropped
//   clr_en_i/clr_addr_i zero-write of one row from the clear sequencer
//   in_valid_i, in_mode_i, in_addr_i, in_data_i   write request
//   rd_en_i, rd_addr_i, rd_valid_o, rd_data_o     read port
//   sat_flag_o          one-cycle pulse after a saturated write
module accum_bank_col
  import accum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidthDef,
  parameter int unsigned ACC_WIDTH  = AccWidthDef,
  parameter int unsigned DEPTH      = 1024,
  parameter int unsigned ADDR_W     = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  busy_i,
  input  logic                  clr_en_i,
  input  logic [ADDR_W-1:0]     clr_addr_i,
  input  logic                  in_valid_i,
  input  logic                  in_mode_i,
  input  logic [ADDR_W-1:0]     in_addr_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  rd_en_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic                  rd_valid_o,
  output logic [ACC_WIDTH-1:0]  rd_data_o,
  output logic                  sat_flag_o
);

  logic [ACC_WIDTH-1:0] mem_q [DEPTH];

  logic                  s1_valid_q, s1_valid_d;
  accum_mode_e           s1_mode_q, s1_mode_d;
  logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
  logic [DATA_WIDTH-1:0] s1_data_q, s1_data_d;
  logic [ACC_WIDTH-1:0]  s1_old_q, s1_old_d;
  logic                  rd_valid_q, rd_valid_d;
  logic [ACC_WIDTH-1:0]  rd_data_q, rd_data_d;

  logic [ACC_WIDTH-1:0]  ext_data;
  logic [ACC_WIDTH-1:0]  wr_val;

  assign ext_data = ACC_WIDTH'($signed(s1_data_q));

`ifdef ACCUM_BANK_SAT_EN
  logic [ACC_WIDTH:0] sum_wide;
  logic               ovf;
  logic               sat_flag_q, sat_flag_d;

  always_comb begin
    sum_wide   = {s1_old_q[ACC_WIDTH-1], s1_old_q} + {ext_data[ACC_WIDTH-1], ext_data};
    ovf        = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];
    sat_flag_d = 1'b0;
    if (s1_mode_q == ModeOverwrite) begin
      wr_val = ext_data;
    end else if (ovf) begin
      // Carry-out sign tells the overflow direction.
      wr_val     = sum_wide[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      sat_flag_d = s1_valid_q;
    end else begin
      wr_val = sum_wide[ACC_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sat_flag_q <= 1'b0;
    else       sat_flag_q <= sat_flag_d;
  end

  assign sat_flag_o = sat_flag_q;
`else
  always_comb begin
    wr_val = s1_old_q + ext_data;
    if (s1_mode_q == ModeOverwrite) wr_val = ext_data;
  end

  assign sat_flag_o = 1'b0;
`endif

  always_comb begin
    s1_valid_d = in_valid_i & ~busy_i;
    s1_mode_d  = accum_mode_e'(in_mode_i);
    s1_addr_d  = in_addr_i;
    s1_data_d  = in_data_i;
    // The RAM still holds the pre-write value of a row stage 2 is updating
    // this cycle, so take the stage-2 result instead.
    if (s1_valid_q && (s1_addr_q == in_addr_i)) s1_old_d = wr_val;
    else                                        s1_old_d = mem_q[in_addr_i];

    rd_valid_d = rd_en_i & ~busy_i;
    rd_data_d  = rd_valid_d ? mem_q[rd_addr_i] : rd_data_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_mode_q  <= ModeAccum;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s1_old_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_mode_q  <= s1_mode_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s1_old_q   <= s1_old_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Clear write is issued last so it wins over a same-row stage-2 write.
  always_ff @(posedge clk_i) begin
    if (s1_valid_q) mem_q[s1_addr_q] <= wr_val;
    if (clr_en_i)   mem_q[clr_addr_i] <= '0;
  end

  assign rd_valid_o = rd_valid_q & ~busy_i;
  assign rd_data_o  = rd_data_q;

endmodule

// File: rtl/accum_bank.sv
// Bank of SYS_ARR_COLS independent accumulator columns plus the table clear
// sequencer. After every reset, and on clear_start, all rows of all columns
// are zeroed one row per cycle while busy is high.
// Optional saturation: define ACCUM_BANK_SAT_EN (handled in accum_bank_col).
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid/in_mode/in_addr/in_data   per-column write requests (mode shared)
//   rd_en/rd_addr/rd_valid/rd_data     per-column 1-cycle read port
//   clear_start, busy          clear request and sweep-in-progress
//   sat_flag                   per-column saturation pulse
module accum_bank
  import accum_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = DataWidthDef,
  parameter int unsigned ACC_WIDTH    = AccWidthDef,
  parameter int unsigned SYS_ARR_COLS = SysArrColsDef,
  parameter int unsigned MAX_OUT_ROWS = MaxOutRowsDef,
  parameter int unsigned MAX_OUT_COLS = MaxOutColsDef,
  localparam int unsigned DEPTH       = MAX_OUT_ROWS * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SYS_ARR_COLS-1:0]            in_valid,
  input  logic                               in_mode,
  input  logic [ADDR_W*SYS_ARR_COLS-1:0]     in_addr,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] in_data,
  input  logic [SYS_ARR_COLS-1:0]            rd_en,
  input  logic [ADDR_W*SYS_ARR_COLS-1:0]     rd_addr,
  output logic [SYS_ARR_COLS-1:0]            rd_valid,
  output logic [ACC_WIDTH*SYS_ARR_COLS-1:0]  rd_data,
  input  logic                               clear_start,
  output logic                               busy,
  output logic [SYS_ARR_COLS-1:0]            sat_flag
);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
          cnt_d   = '0;
        end
      end
      StClear: begin
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
    endcase
  end

  // Reset lands in the sweep so the uninitialised RAM is always zeroed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StClear;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q == StClear);

  for (genvar c = 0; c < SYS_ARR_COLS; c++) begin : g_col
    accum_bank_col #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .DEPTH     (DEPTH),
      .ADDR_W    (ADDR_W)
    ) u_col (
      .clk_i     (clk),
      .rst_i     (reset),
      .busy_i    (busy),
      .clr_en_i  (busy),
      .clr_addr_i(cnt_q),
      .in_valid_i(in_valid[c]),
      .in_mode_i (in_mode),
      .in_addr_i (in_addr[c*ADDR_W +: ADDR_W]),
      .in_data_i (in_data[c*DATA_WIDTH +: DATA_WIDTH]),
      .rd_en_i   (rd_en[c]),
      .rd_addr_i (rd_addr[c*ADDR_W +: ADDR_W]),
      .rd_valid_o(rd_valid[c]),
      .rd_data_o (rd_data[c*ACC_WIDTH +: ACC_WIDTH]),
      .sat_flag_o(sat_flag[c])
    );
  end

endmodule

// File: tb/tb_accum_bank.sv
// Directed bench for accum_bank: table of single write/read-back vectors plus
// hand-written sequences for forwarding, read/write collision, saturation,
// clear sweep and reset during a sweep. 32-bit data so full-width overwrites
// are possible.
module tb_accum_bank;

  localparam int unsigned Cols  = 16;
  localparam int unsigned Dw    = 32;
  localparam int unsigned Aw    = 32;
  localparam int unsigned Depth = 1024;
  localparam int unsigned Abw   = 10;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [Cols-1:0]    in_valid;
  logic               in_mode;
  logic [Abw*Cols-1:0] in_addr;
  logic [Dw*Cols-1:0] in_data;
  logic [Cols-1:0]    rd_en;
  logic [Abw*Cols-1:0] rd_addr;
  logic [Cols-1:0]    rd_valid;
  logic [Aw*Cols-1:0] rd_data;
  logic               clear_start;
  logic               busy;
  logic [Cols-1:0]    sat_flag;

  always #5 clk = ~clk;

  accum_bank #(
    .DATA_WIDTH  (Dw),
    .ACC_WIDTH   (Aw),
    .SYS_ARR_COLS(Cols),
    .MAX_OUT_ROWS(128),
    .MAX_OUT_COLS(128)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_mode    (in_mode),
    .in_addr    (in_addr),
    .in_data    (in_data),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .clear_start(clear_start),
    .busy       (busy),
    .sat_flag   (sat_flag)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  int sat_cnt      = 0;

  always @(negedge clk) begin
    if (!reset) sat_cnt = sat_cnt + $countones(sat_flag);
  end

  typedef struct {
    int          col;
    int          addr;
    logic        mode;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_op(input int col, input int addr, input logic mode,
                          input logic [31:0] data);
    in_valid = '0;
    in_valid[col] = 1'b1;
    in_mode = mode;
    in_addr[col*Abw +: Abw] = Abw'(addr);
    in_data[col*Dw +: Dw] = data;
    tick();
    in_valid = '0;
  endtask

  task automatic read_op(input int col, input int addr, output logic [31:0] val,
                         output logic vld);
    rd_en = '0;
    rd_en[col] = 1'b1;
    rd_addr[col*Abw +: Abw] = Abw'(addr);
    tick();
    rd_en = '0;
    vld = rd_valid[col];
    val = rd_data[col*Aw +: Aw];
  endtask

  task automatic wait_busy_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  // Reads every row of every column in parallel; counts rows that are not 0.
  task automatic scan_zero(output int bad);
    bad = 0;
    for (int r = 0; r < Depth; r++) begin
      rd_en = '1;
      for (int c = 0; c < Cols; c++) rd_addr[c*Abw +: Abw] = Abw'(r);
      tick();
      if (rd_valid !== '1 || rd_data !== '0) bad++;
    end
    rd_en = '0;
  endtask

  initial begin
    logic [31:0] val;
    logic        vld;
    int          n;
    int          bad;
    int          viol;
    int          s0;

    in_valid    = '0;
    in_mode     = 1'b0;
    in_addr     = '0;
    in_data     = '0;
    rd_en       = '0;
    rd_addr     = '0;
    clear_start = 1'b0;

    vecs[0]  = '{0,  10,   1'b1, 32'h0000_1234, 32'h0000_1234};
    vecs[1]  = '{0,  10,   1'b0, 32'h0000_0010, 32'h0000_1244};
    vecs[2]  = '{0,  10,   1'b0, 32'hFFFF_EDBC, 32'h0000_0000};
    vecs[3]  = '{15, 1023, 1'b0, 32'h0000_0005, 32'h0000_0005};
    vecs[4]  = '{15, 1023, 1'b0, 32'hFFFF_FFF6, 32'hFFFF_FFFB};
    vecs[5]  = '{7,  0,    1'b1, 32'h8000_0000, 32'h8000_0000};
`ifdef ACCUM_BANK_SAT_EN
    vecs[6]  = '{7,  0,    1'b0, 32'hFFFF_FFFF, 32'h8000_0000};
`else
    vecs[6]  = '{7,  0,    1'b0, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
`endif
    vecs[7]  = '{8,  10,   1'b0, 32'h0000_0003, 32'h0000_0003};
    vecs[8]  = '{0,  10,   1'b0, 32'h0000_0007, 32'h0000_0007};
    vecs[9]  = '{2,  512,  1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[10] = '{2,  512,  1'b1, 32'h0000_0001, 32'h0000_0001};

    // Reset state.
    repeat (3) tick();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data_any", 32'(|rd_data), 32'd0);
    check("rst_sat_flag", 32'(sat_flag), 32'd0);

    // Initial sweep after reset release.
    reset = 1'b0;
    wait_busy_done(n);
    check("init_busy_cycles", n, 32'd1024);
    scan_zero(bad);
    check("init_rows_zero", bad, 32'd0);

    // Isolated write then read two cycles after the request.
    for (int i = 0; i < 11; i++) begin
      write_op(vecs[i].col, vecs[i].addr, vecs[i].mode, vecs[i].data);
      tick();
      read_op(vecs[i].col, vecs[i].addr, val, vld);
      check($sformatf("vec%0d_data", i), val, vecs[i].exp);
      check($sformatf("vec%0d_valid", i), 32'(vld), 32'd1);
    end
    tick();
    check("idle_rd_valid", 32'(rd_valid), 32'd0);

    // Back-to-back accumulates to one row: 10 - 3 + 7.
    write_op(3, 5, 1'b0, 32'd10);
    write_op(3, 5, 1'b0, 32'hFFFF_FFFD);
    write_op(3, 5, 1'b0, 32'd7);
    tick();
    read_op(3, 5, val, vld);
    check("fwd_accum", val, 32'd14);

    // Read in the write cycle sees the old value; then accumulate 1.
    write_op(4, 7, 1'b1, 32'd100);
    read_op(4, 7, val, vld);
    check("collide_old", val, 32'd0);
    write_op(4, 7, 1'b0, 32'd1);
    tick();
    read_op(4, 7, val, vld);
    check("ovw_then_acc", val, 32'd101);

    // Positive overflow.
    s0 = sat_cnt;
    write_op(5, 9, 1'b1, 32'h7FFF_FFF0);
    write_op(5, 9, 1'b0, 32'h0000_7FFF);
    tick();
    read_op(5, 9, val, vld);
    repeat (3) tick();
`ifdef ACCUM_BANK_SAT_EN
    check("sat_value", val, 32'h7FFF_FFFF);
    check("sat_pulses", sat_cnt - s0, 32'd1);
`else
    check("wrap_value", val, 32'h8000_7FEF);
    check("sat_pulses", sat_cnt - s0, 32'd0);
`endif

    // Clear with traffic before, at, and during the sweep.
    write_op(6, 20, 1'b1, 32'd77);
    in_valid = '0;
    in_valid[6] = 1'b1;
    in_mode = 1'b1;
    in_addr[6*Abw +: Abw] = '0;
    in_data[6*Dw +: Dw] = 32'd99;
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    in_valid = '1;
    rd_en = '1;
    for (int c = 0; c < Cols; c++) begin
      in_addr[c*Abw +: Abw] = Abw'(3);
      in_data[c*Dw +: Dw] = 32'd55;
    end
    n = 0;
    viol = 0;
    while (busy === 1'b1 && n < 2000) begin
      tick();
      n++;
      if (busy === 1'b1 && rd_valid !== '0) viol++;
    end
    in_valid = '0;
    rd_en = '0;
    check("clr_busy_cycles", n, 32'd1024);
    check("clr_rd_valid_low", viol, 32'd0);
    scan_zero(bad);
    check("clr_rows_zero", bad, 32'd0);

    // Reset 500 cycles into a sweep restarts it from row 0.
    write_op(9, 700, 1'b1, 32'd5);
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (500) tick();
    reset = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    wait_busy_done(n);
    check("mid_rst_busy_cycles", n, 32'd1024);
    write_op(9, 700, 1'b0, 32'd2);
    tick();
    read_op(9, 700, val, vld);
    check("post_rst_accum", val, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
